// File: rtl/writeport_pkg.sv
// Shared constants, state and fail-code encodings for the write-port checker.
// Latency: n/a (declarations only).  Backpressure: n/a.
// Golden scalar values and the array base pattern live here so RTL has one source.
package writeport_pkg;

  localparam logic         EXP_BIT    = 1'b1;
  localparam logic [7:0]   EXP_BYTE   = 8'hEF;
  localparam logic [15:0]  EXP_HALF   = 16'hCDEF;
  localparam logic [31:0]  EXP_WORD   = 32'h89AB_CDEF;
  localparam logic [63:0]  EXP_DOUBLE = 64'h0123_4567_89AB_CDEF;
  localparam logic [127:0] EXP_QUAD   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] ARR_BASE   = 128'h0123_4567_89AB_CD00_FEDC_BA98_7654_3200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHK_SCALAR,
    ST_CHK_ARRAY,
    ST_PASS,
    ST_FAIL
  } state_t;

  typedef enum logic [3:0] {
    FC_NONE          = 4'd0,
    FC_BIT           = 4'd1,
    FC_BYTE          = 4'd2,
    FC_HALF          = 4'd3,
    FC_WORD          = 4'd4,
    FC_DOUBLE        = 4'd5,
    FC_QUAD          = 4'd6,
    FC_NO_SCALAR     = 4'd7,
    FC_ARR_DATA      = 4'd8,
    FC_ARR_UNWRITTEN = 4'd9
  } fail_code_t;

  // Entry k carries its own index in the low byte of each 64-bit half.
  function automatic logic [127:0] arr_expected(input logic [7:0] k);
    arr_expected = ARR_BASE | {56'b0, k, 56'b0, k};
  endfunction

endpackage

// File: rtl/writeport_array_store.sv
// 128-bit-wide entry storage with per-entry written mask and distinct-fill counter.
// Latency: write lands on the next rising edge; read port is combinational.
// Backpressure: none; every wr_en cycle is stored.
module writeport_array_store #(
  parameter int DEPTH = 128,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [127:0]       wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [127:0]       rd_data,
  output logic               rd_written,
`ifdef WRITEPORT_READBACK_EN
  input  logic [IDX_W-1:0]   rb_idx,
  output logic [127:0]       rb_data,
  output logic [7:0]         fill
`else
  output logic [7:0]         fill
`endif
);

  logic [127:0]     mem [DEPTH];
  logic [DEPTH-1:0] written;

  // Data storage is deliberately left out of reset; the written mask gates it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      fill    <= '0;
    end else if (wr_en) begin
      written[wr_idx] <= 1'b1;
      if (!written[wr_idx]) fill <= fill + 8'd1;
    end
  end

  assign rd_data    = mem[rd_idx];
  assign rd_written = written[rd_idx];

`ifdef WRITEPORT_READBACK_EN
  assign rb_data = mem[rb_idx];
`endif

endmodule

// File: rtl/writeport_checker.sv
// Collects scalar/array writes, then checks them against golden values (optional readback: WRITEPORT_READBACK_EN).
// Latency: done accepted at edge N gives PASS after edge N+1+ARRAY_DEPTH; a failure one edge after its check.
// Backpressure: ready=1 only in IDLE/COLLECT; writes and done are dropped otherwise.
module writeport_checker
  import writeport_pkg::*;
#(
  parameter int ARRAY_DEPTH = 128,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(ARRAY_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write_port,
  input  logic [7:0]         write_byte_port,
  input  logic [15:0]        write_half_port,
  input  logic [31:0]        write_word_port,
  input  logic [63:0]        write_double_port,
  input  logic [127:0]       write_quad_port,
  input  logic               write_valid,
  input  logic               arr_valid,
  input  logic [IDX_W-1:0]   arr_idx,
  input  logic [127:0]       arr_data,
  input  logic               done,
  output logic               ready,
  output logic [CNT_W-1:0]   write_count,
  output logic [7:0]         arr_fill,
  output logic [1:0]         status,
  output logic [3:0]         fail_code,
`ifdef WRITEPORT_READBACK_EN
  output logic [IDX_W-1:0]   fail_idx,
  input  logic [IDX_W-1:0]   rb_idx,
  output logic [127:0]       rb_data
`else
  output logic [IDX_W-1:0]   fail_idx
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_DEPTH - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] chk_idx, chk_idx_nxt;
  logic             fail_set;
  fail_code_t       fail_code_nxt, scalar_code;
  logic [IDX_W-1:0] fail_idx_nxt;

  logic             wr_acc, arr_acc, done_acc;
  logic             scalar_written;
  logic             s_bit;
  logic [7:0]       s_byte;
  logic [15:0]      s_half;
  logic [31:0]      s_word;
  logic [63:0]      s_double;
  logic [127:0]     s_quad;
  logic [127:0]     chk_data;
  logic             chk_written;

  assign ready    = (state == ST_IDLE) || (state == ST_COLLECT);
  assign wr_acc   = ready & write_valid;
  assign arr_acc  = ready & arr_valid;
  assign done_acc = ready & done;

  writeport_array_store #(.DEPTH(ARRAY_DEPTH)) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (arr_acc),
    .wr_idx     (arr_idx),
    .wr_data    (arr_data),
    .rd_idx     (chk_idx),
    .rd_data    (chk_data),
    .rd_written (chk_written),
`ifdef WRITEPORT_READBACK_EN
    .rb_idx     (rb_idx),
    .rb_data    (rb_data),
    .fill       (arr_fill)
`else
    .fill       (arr_fill)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scalar_written <= 1'b0;
      s_bit          <= 1'b0;
      s_byte         <= '0;
      s_half         <= '0;
      s_word         <= '0;
      s_double       <= '0;
      s_quad         <= '0;
      write_count    <= '0;
    end else if (wr_acc) begin
      scalar_written <= 1'b1;
      s_bit          <= write_port;
      s_byte         <= write_byte_port;
      s_half         <= write_half_port;
      s_word         <= write_word_port;
      s_double       <= write_double_port;
      s_quad         <= write_quad_port;
      if (write_count != {CNT_W{1'b1}}) write_count <= write_count + CNT_W'(1);
    end
  end

  // Priority order gives the lowest code when several fields disagree.
  always_comb begin
    scalar_code = FC_NONE;
    if (!scalar_written)           scalar_code = FC_NO_SCALAR;
    else if (s_bit    != EXP_BIT)    scalar_code = FC_BIT;
    else if (s_byte   != EXP_BYTE)   scalar_code = FC_BYTE;
    else if (s_half   != EXP_HALF)   scalar_code = FC_HALF;
    else if (s_word   != EXP_WORD)   scalar_code = FC_WORD;
    else if (s_double != EXP_DOUBLE) scalar_code = FC_DOUBLE;
    else if (s_quad   != EXP_QUAD)   scalar_code = FC_QUAD;
  end

  always_comb begin
    state_nxt     = state;
    chk_idx_nxt   = chk_idx;
    fail_set      = 1'b0;
    fail_code_nxt = FC_NONE;
    fail_idx_nxt  = '0;
    unique case (state)
      ST_IDLE: begin
        if (done_acc)              state_nxt = ST_CHK_SCALAR;
        else if (wr_acc || arr_acc) state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (done_acc) state_nxt = ST_CHK_SCALAR;
      end
      ST_CHK_SCALAR: begin
        chk_idx_nxt = '0;
        if (scalar_code != FC_NONE) begin
          state_nxt     = ST_FAIL;
          fail_set      = 1'b1;
          fail_code_nxt = scalar_code;
        end else begin
          state_nxt = ST_CHK_ARRAY;
        end
      end
      ST_CHK_ARRAY: begin
        if (!chk_written) begin
          state_nxt     = ST_FAIL;
          fail_set      = 1'b1;
          fail_code_nxt = FC_ARR_UNWRITTEN;
          fail_idx_nxt  = chk_idx;
        end else if (chk_data != arr_expected(8'(chk_idx))) begin
          state_nxt     = ST_FAIL;
          fail_set      = 1'b1;
          fail_code_nxt = FC_ARR_DATA;
          fail_idx_nxt  = chk_idx;
        end else if (chk_idx == LAST_IDX) begin
          state_nxt = ST_PASS;
        end else begin
          chk_idx_nxt = chk_idx + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      chk_idx   <= '0;
      fail_code <= '0;
      fail_idx  <= '0;
    end else begin
      state   <= state_nxt;
      chk_idx <= chk_idx_nxt;
      if (fail_set) begin
        fail_code <= fail_code_nxt;
        fail_idx  <= fail_idx_nxt;
      end
    end
  end

  always_comb begin
    status = 2'b00;
    if (state == ST_PASS)      status = 2'b01;
    else if (state == ST_FAIL) status = 2'b10;
  end

endmodule
